// File: rtl/cr16_pkg.sv
// cr16_pkg: ALU opcode constants, flag bit positions and flag helpers shared
// by the CR16 datapath family.
package cr16_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD  = 4'h0;  // a + b
  localparam opcode_t OP_SUB  = 4'h1;  // a - b
  localparam opcode_t OP_AND  = 4'h2;
  localparam opcode_t OP_OR   = 4'h3;
  localparam opcode_t OP_XOR  = 4'h4;
  localparam opcode_t OP_NOT  = 4'h5;  // ~a
  localparam opcode_t OP_MOV  = 4'h6;  // pass a (register or immediate)
  localparam opcode_t OP_LSH  = 4'h7;  // a << b
  localparam opcode_t OP_RSH  = 4'h8;  // a >> b, logical
  localparam opcode_t OP_ASHR = 4'h9;  // a >>> b, arithmetic

  localparam int FLAG_W = 5;
  localparam int FLAG_C = 0;  // carry out / borrow
  localparam int FLAG_L = 1;  // a < b, unsigned
  localparam int FLAG_F = 2;  // signed overflow
  localparam int FLAG_Z = 3;  // result is zero
  localparam int FLAG_N = 4;  // result is negative

  typedef logic [FLAG_W-1:0] flags_t;

  // Assemble a flags word from individual condition bits.
  function automatic flags_t pack_flags(input logic c, input logic l,
                                        input logic f, input logic z,
                                        input logic n);
    flags_t fl;
    fl         = '0;
    fl[FLAG_C] = c;
    fl[FLAG_L] = l;
    fl[FLAG_F] = f;
    fl[FLAG_Z] = z;
    fl[FLAG_N] = n;
    return fl;
  endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational CR16 ALU, parameterised width. Carry out of the top bit
// only reaches the flags, never the result.
module alu
  import cr16_pkg::*;
#(
  parameter int P_WIDTH = 16
) (
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  input  opcode_t            opcode,
  output logic [P_WIDTH-1:0] result,
  output flags_t             flags
);

  localparam int SH_W = $clog2(P_WIDTH);
  localparam int MSB  = P_WIDTH - 1;

  logic [P_WIDTH:0] sum;
  logic [P_WIDTH:0] diff;
  logic             carry;
  logic             ovf;

  // Result and carry/overflow selection per opcode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    case (opcode)
      OP_ADD: begin
        result = sum[MSB:0];
        carry  = sum[P_WIDTH];
        ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        result = diff[MSB:0];
        carry  = diff[P_WIDTH];
        ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_MOV:  result = a;
      OP_LSH:  result = a << b[SH_W-1:0];
      OP_RSH:  result = a >> b[SH_W-1:0];
      OP_ASHR: result = $signed(a) >>> b[SH_W-1:0];
      default: result = '0;
    endcase
  end

  assign flags = pack_flags(carry, (a < b), ovf, (result == '0), result[MSB]);

endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with one synchronous write port and two
// combinational read ports. Optional hardwired-zero r0.
module regfile_2r1w #(
  parameter  int P_WIDTH    = 16,
  parameter  int P_NUM_REGS = 16,
  parameter  int P_ZERO_REG = 0,
  localparam int P_SEL      = $clog2(P_NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [P_SEL-1:0]   waddr,
  input  logic [P_WIDTH-1:0] wdata,
  input  logic [P_SEL-1:0]   raddr_a,
  input  logic [P_SEL-1:0]   raddr_b,
  output logic [P_WIDTH-1:0] rdata_a,
  output logic [P_WIDTH-1:0] rdata_b
);

  logic [P_WIDTH-1:0] regs [P_NUM_REGS];
  logic               wr_zero;

  assign wr_zero = (P_ZERO_REG != 0) && (waddr == '0);

  // Register array: cleared on reset, single write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this array is small flops, not a RAM macro, and must read as zero
      // after reset, so every entry is cleared explicitly.
      for (int i = 0; i < P_NUM_REGS; i++) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        regs[i] <= '0;
      end
    end else if (we && !wr_zero) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = ((P_ZERO_REG != 0) && (raddr_a == '0)) ? '0 : regs[raddr_a];
  assign rdata_b = ((P_ZERO_REG != 0) && (raddr_b == '0)) ? '0 : regs[raddr_b];

endmodule

// File: rtl/datapath_pipelined.sv
// datapath_pipelined: two-stage CR16 datapath. RD stage reads (or forwards)
// operands into the EX register; EX stage computes and writes back on the
// next enabled edge. I_ENABLE low freezes every register.
module datapath_pipelined
  import cr16_pkg::*;
#(
  parameter  int P_WIDTH    = 16,
  parameter  int P_NUM_REGS = 16,
  parameter  int P_ZERO_REG = 0,
  localparam int P_SEL      = $clog2(P_NUM_REGS)
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic               I_ENABLE,
  input  logic               I_VALID,
  output logic               O_READY,
  input  logic [3:0]         I_OPCODE,
  input  logic [P_SEL-1:0]   I_REG_A_SELECT,
  input  logic [P_SEL-1:0]   I_REG_B_SELECT,
  input  logic [P_SEL-1:0]   I_REG_DEST_SELECT,
  input  logic               I_REG_WRITE,
  input  logic [P_WIDTH-1:0] I_IMMEDIATE,
  input  logic               I_IMMEDIATE_SELECT,
  input  logic [P_WIDTH-1:0] I_REGFILE_DATA,
  input  logic               I_REGFILE_DATA_SELECT,
  input  logic               I_FLAGS_WRITE,
  input  logic [4:0]         I_STATUS_FLAGS,
  input  logic               I_STATUS_FLAGS_SELECT,
  output logic [P_WIDTH-1:0] O_A,
  output logic [P_WIDTH-1:0] O_B,
  output logic               O_RESULT_VALID,
  output logic [P_WIDTH-1:0] O_RESULT,
  output logic [P_SEL-1:0]   O_RESULT_DEST,
  output logic [4:0]         O_STATUS_FLAGS
);

  // Everything the EX stage needs about one accepted operation.
  typedef struct packed {
    logic [P_WIDTH-1:0] a;
    logic [P_WIDTH-1:0] b;
    opcode_t            op;
    logic [P_SEL-1:0]   dest;
    logic               write;
    logic               flags_write;
    logic               status_sel;
    flags_t             status_flags;
    logic [P_WIDTH-1:0] rf_data;
    logic               rf_data_sel;
  } ex_t;

  ex_t                ex;
  logic               ex_valid;
  logic               accept;
  logic               wb_fire;
  logic [P_WIDTH-1:0] rf_a;
  logic [P_WIDTH-1:0] rf_b;
  logic [P_WIDTH-1:0] alu_result;
  flags_t             alu_flags;
  logic [P_WIDTH-1:0] ex_result;
  logic               ex_fwd_ok;
  logic               fwd_a;
  logic               fwd_b;
  logic [P_WIDTH-1:0] opnd_a;
  logic [P_WIDTH-1:0] opnd_b;

  assign O_READY = I_ENABLE;
  assign accept  = I_VALID && O_READY;
  assign wb_fire = ex_valid && I_ENABLE;

  regfile_2r1w #(
    .P_WIDTH    (P_WIDTH),
    .P_NUM_REGS (P_NUM_REGS),
    .P_ZERO_REG (P_ZERO_REG)
  ) u_regfile (
    .clk     (I_CLK),
    .rst     (I_RESET),
    .we      (wb_fire && ex.write),
    .waddr   (ex.dest),
    .wdata   (ex_result),
    .raddr_a (I_REG_A_SELECT),
    .raddr_b (I_REG_B_SELECT),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  alu #(
    .P_WIDTH (P_WIDTH)
  ) u_alu (
    .a      (ex.a),
    .b      (ex.b),
    .opcode (ex.op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  assign ex_result = ex.rf_data_sel ? ex.rf_data : alu_result;

  // The EX result is forwardable only if it will actually land in the
  // register file; a write aimed at a hardwired-zero r0 never does.
  assign ex_fwd_ok = ex_valid && ex.write &&
                     !((P_ZERO_REG != 0) && (ex.dest == '0));
  assign fwd_a     = ex_fwd_ok && (ex.dest == I_REG_A_SELECT);
  assign fwd_b     = ex_fwd_ok && (ex.dest == I_REG_B_SELECT);
  assign opnd_a    = I_IMMEDIATE_SELECT ? I_IMMEDIATE :
                     (fwd_a ? ex_result : rf_a);
  assign opnd_b    = fwd_b ? ex_result : rf_b;

  // RD -> EX pipeline register; an enabled cycle without an issue is a bubble.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      ex       <= '0;
      ex_valid <= 1'b0;
    end else if (I_ENABLE) begin
      ex_valid <= accept;
      if (accept) begin
        ex.a            <= opnd_a;
        ex.b            <= opnd_b;
        ex.op           <= I_OPCODE;
        ex.dest         <= I_REG_DEST_SELECT;
        ex.write        <= I_REG_WRITE;
        ex.flags_write  <= I_FLAGS_WRITE;
        ex.status_sel   <= I_STATUS_FLAGS_SELECT;
        ex.status_flags <= I_STATUS_FLAGS;
        ex.rf_data      <= I_REGFILE_DATA;
        ex.rf_data_sel  <= I_REGFILE_DATA_SELECT;
      end
    end
  end

  // Writeback of flags and the registered result bus.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      O_STATUS_FLAGS <= '0;
      O_RESULT       <= '0;
      O_RESULT_DEST  <= '0;
      O_RESULT_VALID <= 1'b0;
    end else if (I_ENABLE) begin
      O_RESULT_VALID <= ex_valid;
      if (ex_valid) begin
        O_RESULT      <= ex_result;
        O_RESULT_DEST <= ex.dest;
        if (ex.flags_write) begin
          O_STATUS_FLAGS <= ex.status_sel ? ex.status_flags : alu_flags;
        end
      end
    end
  end

  assign O_A = ex.a;
  assign O_B = ex.b;

endmodule

// File: tb/tb_datapath_pipelined.sv
// tb_datapath_pipelined: directed scenarios against two instances, one with a
// plain r0 and one with a hardwired-zero r0, both driven by the same stimulus.
module tb_datapath_pipelined;
  import cr16_pkg::*;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        valid;
  logic [3:0]  opcode;
  logic [3:0]  sel_a, sel_b, sel_d;
  logic        reg_write;
  logic [15:0] imm;
  logic        imm_sel;
  logic [15:0] rf_data;
  logic        rf_data_sel;
  logic        flags_write;
  logic [4:0]  status_flags;
  logic        status_sel;

  logic        o_ready0, o_valid0, o_ready1, o_valid1;
  logic [15:0] o_a0, o_b0, o_result0, o_a1, o_b1, o_result1;
  logic [3:0]  o_dest0, o_dest1;
  logic [4:0]  o_flags0, o_flags1;

  int nvec  = 0;
  int nfail = 0;

  datapath_pipelined #(.P_WIDTH(16), .P_NUM_REGS(16), .P_ZERO_REG(0)) dut0 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(enable), .I_VALID(valid), .O_READY(o_ready0),
    .I_OPCODE(opcode), .I_REG_A_SELECT(sel_a), .I_REG_B_SELECT(sel_b),
    .I_REG_DEST_SELECT(sel_d), .I_REG_WRITE(reg_write), .I_IMMEDIATE(imm),
    .I_IMMEDIATE_SELECT(imm_sel), .I_REGFILE_DATA(rf_data),
    .I_REGFILE_DATA_SELECT(rf_data_sel), .I_FLAGS_WRITE(flags_write),
    .I_STATUS_FLAGS(status_flags), .I_STATUS_FLAGS_SELECT(status_sel),
    .O_A(o_a0), .O_B(o_b0), .O_RESULT_VALID(o_valid0), .O_RESULT(o_result0),
    .O_RESULT_DEST(o_dest0), .O_STATUS_FLAGS(o_flags0)
  );

  datapath_pipelined #(.P_WIDTH(16), .P_NUM_REGS(16), .P_ZERO_REG(1)) dut1 (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(enable), .I_VALID(valid), .O_READY(o_ready1),
    .I_OPCODE(opcode), .I_REG_A_SELECT(sel_a), .I_REG_B_SELECT(sel_b),
    .I_REG_DEST_SELECT(sel_d), .I_REG_WRITE(reg_write), .I_IMMEDIATE(imm),
    .I_IMMEDIATE_SELECT(imm_sel), .I_REGFILE_DATA(rf_data),
    .I_REGFILE_DATA_SELECT(rf_data_sel), .I_FLAGS_WRITE(flags_write),
    .I_STATUS_FLAGS(status_flags), .I_STATUS_FLAGS_SELECT(status_sel),
    .O_A(o_a1), .O_B(o_b1), .O_RESULT_VALID(o_valid1), .O_RESULT(o_result1),
    .O_RESULT_DEST(o_dest1), .O_STATUS_FLAGS(o_flags1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid        = 1'b0;
    opcode       = OP_ADD;
    sel_a        = '0;
    sel_b        = '0;
    sel_d        = '0;
    reg_write    = 1'b0;
    imm          = '0;
    imm_sel      = 1'b0;
    rf_data      = '0;
    rf_data_sel  = 1'b0;
    flags_write  = 1'b0;
    status_flags = '0;
    status_sel   = 1'b0;
  endtask

  task automatic load(input logic [3:0] d, input logic [15:0] v);
    clear_inputs();
    valid       = 1'b1;
    sel_d       = d;
    reg_write   = 1'b1;
    rf_data     = v;
    rf_data_sel = 1'b1;
  endtask

  task automatic alu_op(input opcode_t op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic wr, input logic fw);
    clear_inputs();
    valid       = 1'b1;
    opcode      = op;
    sel_a       = a;
    sel_b       = b;
    sel_d       = d;
    reg_write   = wr;
    flags_write = fw;
  endtask

  // Read a register through a non-writing MOV; returns both instances' result.
  task automatic read_reg(input logic [3:0] idx, output logic [15:0] v0,
                          output logic [15:0] v1);
    alu_op(OP_MOV, idx, idx, 4'd0, 1'b0, 1'b0);
    step();
    clear_inputs();
    step();
    v0 = o_result0;
    v1 = o_result1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    enable = 1'b1;
    clear_inputs();
    step();
    step();
    nvec++; if (o_result0 !== 16'h0) begin nfail++; $display("FAIL reset_result got %h want 0000", o_result0); end
    nvec++; if (o_valid0 !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", o_valid0); end
    nvec++; if (o_dest0 !== 4'h0) begin nfail++; $display("FAIL reset_dest got %h want 0", o_dest0); end
    nvec++; if (o_flags0 !== 5'b0) begin nfail++; $display("FAIL reset_flags got %b want 00000", o_flags0); end
    nvec++; if ({o_a0, o_b0} !== 32'h0) begin nfail++; $display("FAIL reset_ab got %h/%h want 0/0", o_a0, o_b0); end
    nvec++; if (o_ready0 !== 1'b1) begin nfail++; $display("FAIL ready_hi got %b want 1", o_ready0); end
    enable = 1'b0;
    #1;
    nvec++; if (o_ready0 !== 1'b0) begin nfail++; $display("FAIL ready_lo got %b want 0", o_ready0); end
    enable = 1'b1;
    rst    = 1'b0;
  endtask

  // r1=5, r2=3, then ADD r3 <- r1 + r2 (r2 forwarded from the load in EX).
  task automatic test_add();
    load(4'd1, 16'd5);
    step();
    load(4'd2, 16'd3);
    step();
    nvec++; if (o_result0 !== 16'd5) begin nfail++; $display("FAIL load_r1_result got %h want 0005", o_result0); end
    alu_op(OP_ADD, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0);
    step();
    nvec++; if (o_result0 !== 16'd3 || o_dest0 !== 4'd2) begin nfail++; $display("FAIL load_r2 got %h->r%0d want 0003->r2", o_result0, o_dest0); end
    nvec++; if (o_a0 !== 16'd5 || o_b0 !== 16'd3) begin nfail++; $display("FAIL add_operands got %h/%h want 0005/0003", o_a0, o_b0); end
  endtask

  // ADD r4 <- r3 + r3 issued the very next cycle; r3 must be forwarded.
  task automatic test_back_to_back();
    logic [15:0] v0, v1;
    alu_op(OP_ADD, 4'd3, 4'd3, 4'd4, 1'b1, 1'b0);
    step();
    nvec++; if (o_result0 !== 16'd8 || o_dest0 !== 4'd3 || o_valid0 !== 1'b1) begin nfail++; $display("FAIL add_r3 got %h->r%0d v%b want 0008->r3 v1", o_result0, o_dest0, o_valid0); end
    nvec++; if (o_a0 !== 16'd8 || o_b0 !== 16'd8) begin nfail++; $display("FAIL fwd_operands got %h/%h want 0008/0008", o_a0, o_b0); end
    clear_inputs();
    step();
    nvec++; if (o_result0 !== 16'd16 || o_dest0 !== 4'd4 || o_valid0 !== 1'b1) begin nfail++; $display("FAIL add_r4 got %h->r%0d v%b want 0010->r4 v1", o_result0, o_dest0, o_valid0); end
    step();
    nvec++; if (o_valid0 !== 1'b0 || o_result0 !== 16'd16) begin nfail++; $display("FAIL pulse_end got v%b %h want v0 0010", o_valid0, o_result0); end
    read_reg(4'd3, v0, v1);
    nvec++; if (v0 !== 16'd8) begin nfail++; $display("FAIL r3_readback got %h want 0008", v0); end
    read_reg(4'd4, v0, v1);
    nvec++; if (v0 !== 16'd16) begin nfail++; $display("FAIL r4_readback got %h want 0010", v0); end
  endtask

  // Carry/zero from 0xFFFF+1; borrow/negative/low from immediate 3 - r1(5).
  task automatic test_flags();
    load(4'd5, 16'hFFFF);
    step();
    load(4'd6, 16'h0001);
    step();
    alu_op(OP_ADD, 4'd5, 4'd6, 4'd7, 1'b1, 1'b1);
    step();
    clear_inputs();
    step();
    nvec++; if (o_result0 !== 16'h0000) begin nfail++; $display("FAIL add_wrap_result got %h want 0000", o_result0); end
    nvec++; if (o_flags0 !== 5'b01001) begin nfail++; $display("FAIL add_wrap_flags got %b want 01001", o_flags0); end
    alu_op(OP_SUB, 4'd0, 4'd1, 4'd8, 1'b1, 1'b1);
    imm     = 16'd3;
    imm_sel = 1'b1;
    step();
    clear_inputs();
    step();
    nvec++; if (o_result0 !== 16'hFFFE) begin nfail++; $display("FAIL sub_imm_result got %h want fffe", o_result0); end
    nvec++; if (o_flags0 !== 5'b10011) begin nfail++; $display("FAIL sub_imm_flags got %b want 10011", o_flags0); end
  endtask

  // Hold three cycles with ADD r9 in EX; a request offered during the hold
  // must be ignored, and a dependent op at resume must see r9 forwarded.
  task automatic test_hold();
    logic [15:0] v0, v1;
    clear_inputs();
    step();
    alu_op(OP_ADD, 4'd1, 4'd2, 4'd9, 1'b1, 1'b1);
    step();
    enable = 1'b0;
    load(4'd10, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      step();
      nvec++; if (o_valid0 !== 1'b0 || o_result0 !== 16'hFFFE) begin nfail++; $display("FAIL hold_out_%0d got v%b %h want v0 fffe", i, o_valid0, o_result0); end
      nvec++; if (o_flags0 !== 5'b10011 || o_a0 !== 16'd5) begin nfail++; $display("FAIL hold_state_%0d got %b a=%h want 10011 a=0005", i, o_flags0, o_a0); end
    end
    enable = 1'b1;
    alu_op(OP_ADD, 4'd9, 4'd1, 4'd11, 1'b1, 1'b0);
    step();
    nvec++; if (o_result0 !== 16'd8 || o_dest0 !== 4'd9 || o_valid0 !== 1'b1) begin nfail++; $display("FAIL hold_wb got %h->r%0d v%b want 0008->r9 v1", o_result0, o_dest0, o_valid0); end
    nvec++; if (o_flags0 !== 5'b00000) begin nfail++; $display("FAIL hold_wb_flags got %b want 00000", o_flags0); end
    nvec++; if (o_a0 !== 16'd8 || o_b0 !== 16'd5) begin nfail++; $display("FAIL hold_fwd got %h/%h want 0008/0005", o_a0, o_b0); end
    clear_inputs();
    step();
    nvec++; if (o_result0 !== 16'd13 || o_dest0 !== 4'd11) begin nfail++; $display("FAIL after_hold got %h->r%0d want 000d->r11", o_result0, o_dest0); end
    read_reg(4'd10, v0, v1);
    nvec++; if (v0 !== 16'h0000) begin nfail++; $display("FAIL held_req_dropped got %h want 0000", v0); end
    read_reg(4'd9, v0, v1);
    nvec++; if (v0 !== 16'd8) begin nfail++; $display("FAIL r9_readback got %h want 0008", v0); end
  endtask

  // External flags load, then a reset pulse with ADD r12 sitting in EX.
  task automatic test_status_and_reset();
    logic [15:0] v0, v1;
    clear_inputs();
    valid        = 1'b1;
    flags_write  = 1'b1;
    status_sel   = 1'b1;
    status_flags = 5'b10101;
    step();
    clear_inputs();
    step();
    nvec++; if (o_flags0 !== 5'b10101) begin nfail++; $display("FAIL status_load got %b want 10101", o_flags0); end
    alu_op(OP_ADD, 4'd1, 4'd2, 4'd12, 1'b1, 1'b1);
    step();
    clear_inputs();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    nvec++; if (o_flags0 !== 5'b0 || o_valid0 !== 1'b0 || o_result0 !== 16'h0) begin nfail++; $display("FAIL midop_reset got %b v%b %h want 00000 v0 0000", o_flags0, o_valid0, o_result0); end
    step();
    nvec++; if (o_valid0 !== 1'b0 || o_flags0 !== 5'b0) begin nfail++; $display("FAIL ex_discarded got v%b %b want v0 00000", o_valid0, o_flags0); end
    read_reg(4'd12, v0, v1);
    nvec++; if (v0 !== 16'h0000) begin nfail++; $display("FAIL r12_not_written got %h want 0000", v0); end
    read_reg(4'd1, v0, v1);
    nvec++; if (v0 !== 16'h0000) begin nfail++; $display("FAIL r1_cleared got %h want 0000", v0); end
  endtask

  // Write 0x00FF to r0 then ADD r1 <- r0 + r0: zero-reg instance gives 0.
  task automatic test_zero_reg();
    logic [15:0] v0, v1;
    load(4'd0, 16'h00FF);
    step();
    alu_op(OP_ADD, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    step();
    nvec++; if (o_a1 !== 16'h0 || o_b1 !== 16'h0) begin nfail++; $display("FAIL zr_no_fwd got %h/%h want 0000/0000", o_a1, o_b1); end
    nvec++; if (o_a0 !== 16'h00FF || o_b0 !== 16'h00FF) begin nfail++; $display("FAIL r0_fwd got %h/%h want 00ff/00ff", o_a0, o_b0); end
    clear_inputs();
    step();
    nvec++; if (o_result1 !== 16'h0 || o_dest1 !== 4'd1) begin nfail++; $display("FAIL zr_add got %h->r%0d want 0000->r1", o_result1, o_dest1); end
    nvec++; if (o_result0 !== 16'h01FE) begin nfail++; $display("FAIL r0_add got %h want 01fe", o_result0); end
    read_reg(4'd0, v0, v1);
    nvec++; if (v1 !== 16'h0 || v0 !== 16'h00FF) begin nfail++; $display("FAIL r0_readback got %h/%h want 00ff/0000", v0, v1); end
    read_reg(4'd1, v0, v1);
    nvec++; if (v1 !== 16'h0 || v0 !== 16'h01FE) begin nfail++; $display("FAIL r1_readback got %h/%h want 01fe/0000", v0, v1); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_flags();
    test_hold();
    test_status_and_reset();
    test_zero_reg();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/datapath_pipelined.md
# datapath_pipelined

Parametrised two-stage successor to the single-cycle CR16 datapath: operand-read stage, then execute/writeback stage. Adds configurable width and register count, binary destination select, an optional hardwired zero register, result forwarding, and a valid/ready issue handshake with a global hold. Sits between the controller/decoder and the memory interface; the controller issues one operation per accepted cycle.

## Interface
- P_WIDTH, 16, datapath and register width (≥ 8)
- P_NUM_REGS, 16, register count, power of two ≥ 4; P_SEL = $clog2(P_NUM_REGS)
- P_ZERO_REG, 0, 1 makes r0 read as zero and ignore writes
- I_CLK  in  1  clock, all state on rising edge
- I_RESET  in  1  asynchronous reset, active-high
- I_ENABLE  in  1  low freezes all state (hold)
- I_VALID  in  1  issue request
- O_READY  out  1  = I_ENABLE; issue accepted on edge where I_VALID && O_READY
- I_OPCODE  in  4  ALU opcode (cr16_pkg constants)
- I_REG_A_SELECT, I_REG_B_SELECT, I_REG_DEST_SELECT  in  P_SEL  source/destination indices
- I_REG_WRITE  in  1  write result to destination
- I_IMMEDIATE  in  P_WIDTH  replaces A operand when I_IMMEDIATE_SELECT=1
- I_IMMEDIATE_SELECT  in  1
- I_REGFILE_DATA  in  P_WIDTH  external writeback data; I_REGFILE_DATA_SELECT=1 selects it over ALU result
- I_REGFILE_DATA_SELECT  in  1
- I_FLAGS_WRITE  in  1  update flags register from this operation
- I_STATUS_FLAGS  in  5  loaded into flags when I_STATUS_FLAGS_SELECT=1 and I_FLAGS_WRITE=1
- I_STATUS_FLAGS_SELECT  in  1
- O_A, O_B  out  P_WIDTH  ALU operands of the EX-stage operation
- O_RESULT_VALID  out  1  registered; one pulse per completed operation
- O_RESULT  out  P_WIDTH  registered result bus (value written back)
- O_RESULT_DEST  out  P_SEL  registered destination index
- O_STATUS_FLAGS  out  5  flags register

## Operation
- RD stage (on accept): capture into EX register the A operand (immediate or regfile/forwarded), B operand (regfile/forwarded), opcode, dest, write/flags controls, external data, ex_valid=1. No accept while I_ENABLE=1: ex_valid←0 (bubble).
- Forwarding: if ex_valid && ex_write && ex_dest equals a source index (and not zero reg when P_ZERO_REG=1), capture EX result instead of regfile value. Source equal to dest in the same op reads the old value.
- EX stage (combinational): `alu` computes on captured operands; result = external data if ex_regfile_data_select else ALU output.
- Writeback edge (ex_valid && I_ENABLE): regfile[ex_dest]←result if ex_write (dropped for r0 when P_ZERO_REG=1); flags←I_STATUS_FLAGS-captured or ALU flags if ex_flags_write; O_RESULT/O_RESULT_DEST load; O_RESULT_VALID←1. Otherwise O_RESULT_VALID←0, O_RESULT/DEST hold.
- I_ENABLE=0: no regfile, flags, EX or output updates; O_RESULT_VALID holds its value.
- Width rules: immediate used as-is (sign/zero extension done by decoder); ALU carry out of bit P_WIDTH-1 goes to flags only.

## Timing
- Reset: all registers 0, ex_valid=0, flags=0, O_RESULT=0, O_RESULT_DEST=0, O_RESULT_VALID=0; O_A/O_B=0.
- Latency: accepted at edge N → regfile, flags, O_RESULT updated at edge N+1; back-to-back dependent ops at full rate via forwarding.
- Reset asserted mid-operation discards the EX operation; no write occurs.
- Hold during an in-flight op delays its writeback edge by the hold length; forwarding path stays valid.

## Structure
- cr16_pkg: ALU opcode constants, flag bit indices (C, L, F, Z, N), flag width.
- Sub-module regfile_2r1w (P_WIDTH, P_NUM_REGS, P_ZERO_REG): async reset, one write port, two combinational read ports. Reuse existing `alu` with P_WIDTH.

## Test plan
- Reset then ADD r3←r1+r2 after loading r1=5, r2=3 via I_REGFILE_DATA → O_RESULT=8 at N+1, r3=8, O_RESULT_VALID one pulse.
- Back-to-back ADD r4←r3+r3 issued cycle after r3 op → forwarded, r4=16 with no bubble.
- P_ZERO_REG=1: write 0x00FF to r0, then ADD r1←r0+r0 → r1=0.
- I_ENABLE low 3 cycles with op in EX → no write, flags unchanged; resumes and writes exactly once.
- I_STATUS_FLAGS_SELECT=1, I_STATUS_FLAGS=5'b10101, I_FLAGS_WRITE=1 → O_STATUS_FLAGS=5'b10101 at N+1; I_RESET pulse mid-op → flags 0, no regfile write.
